// File: rtl/dwc_compare_scheduler.sv
// Duplicate-with-compare scheduler: one shared compare engine serving NUM_CH
// core-pair channels. Channels are granted in round-robin order. Each result
// is held until software acknowledges it. Every channel has a saturating
// mismatch counter.
module dwc_compare_scheduler #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8,
    parameter int ID_W   = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        ch_valid_a,
    input  logic [NUM_CH-1:0]        ch_valid_b,
    input  logic [NUM_CH*DATA_W-1:0] ch_data_a,
    input  logic [NUM_CH*DATA_W-1:0] ch_data_b,
    input  logic [NUM_CH-1:0]        ch_ack,
    input  logic                     cnt_clr,
    output logic [NUM_CH-1:0]        ch_done,
    output logic [NUM_CH-1:0]        ch_match,
    output logic                     irq,
    output logic [ID_W-1:0]          irq_ch_id,
    output logic [NUM_CH*CNT_W-1:0]  mismatch_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_CMP, S_RPT} sched_t;
    typedef enum logic [1:0] {CH_WAIT, CH_BUSY, CH_DONE} ch_t;

    sched_t              state;
    sched_t              state_next;
    ch_t                 ch_state [NUM_CH];
    logic [CNT_W-1:0]    cnt      [NUM_CH];

    logic [NUM_CH-1:0]   req;
    logic [NUM_CH-1:0]   rel;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     gnt_id;
    logic                gnt_found;
    logic [ID_W-1:0]     cur_id;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;
    logic [DATA_W-1:0]   cap_a;
    logic [DATA_W-1:0]   cap_b;
    logic                eq;
    logic [NUM_CH-1:0]   match_q;
    logic                irq_q;
    logic [ID_W-1:0]     irq_id_q;

    logic                do_grant;
    logic                do_cmp;
    logic                do_rpt;

    // Per-channel request and release qualifiers
    always_comb begin
        req = '0;
        rel = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            req[i] = (ch_state[i] == CH_WAIT) && ch_valid_a[i] && ch_valid_b[i];
            rel[i] = (ch_state[i] == CH_DONE) && ch_ack[i] && !ch_valid_a[i] && !ch_valid_b[i];
        end
    end

    // Round-robin search: first requester at or after ptr, wrapping at NUM_CH
    always_comb begin
        int unsigned idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = (32'(ptr) + k) % NUM_CH;
            if (!gnt_found && req[ID_W'(idx)]) begin
                gnt_found = 1'b1;
                gnt_id    = ID_W'(idx);
            end
        end
    end

    // Select the granted channel's words for capture
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (gnt_id == ID_W'(i)) begin
                sel_a = ch_data_a[i*DATA_W +: DATA_W];
                sel_b = ch_data_b[i*DATA_W +: DATA_W];
            end
        end
    end

    // Scheduler state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Scheduler next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = gnt_found ? S_CMP : S_IDLE;
            S_CMP:   state_next = S_RPT;
            S_RPT:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Scheduler per-state action strobes
    always_comb begin
        do_grant = 1'b0;
        do_cmp   = 1'b0;
        do_rpt   = 1'b0;
        case (state)
            S_IDLE:  do_grant = gnt_found;
            S_CMP:   do_cmp   = 1'b1;
            S_RPT:   do_rpt   = 1'b1;
            default: ;
        endcase
    end

    // Compare datapath, round-robin pointer and interrupt reporting
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_id   <= '0;
            cap_a    <= '0;
            cap_b    <= '0;
            eq       <= 1'b0;
            ptr      <= '0;
            irq_q    <= 1'b0;
            irq_id_q <= '0;
        end else begin
            irq_q <= do_rpt;
            if (do_grant) begin
                cur_id <= gnt_id;
                cap_a  <= sel_a;
                cap_b  <= sel_b;
            end
            if (do_cmp) begin
                eq <= (cap_a == cap_b);
            end
            if (do_rpt) begin
                irq_id_q <= cur_id;
                ptr      <= (cur_id == ID_W'(NUM_CH - 1)) ? '0 : cur_id + 1'b1;
            end
        end
    end

    // Per-channel WAIT/BUSY/DONE tracking and held match result
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                ch_state[i] <= CH_WAIT;
            end
            match_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (do_grant && gnt_id == ID_W'(i)) begin
                    ch_state[i] <= CH_BUSY;
                end else if (do_rpt && cur_id == ID_W'(i)) begin
                    ch_state[i] <= CH_DONE;
                    match_q[i]  <= eq;
                end else if (rel[i]) begin
                    ch_state[i] <= CH_WAIT;
                    match_q[i]  <= 1'b0;
                end
            end
        end
    end

    // Saturating mismatch counters; clear wins over a coincident increment
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (reset || cnt_clr) begin
                cnt[i] <= '0;
            end else if (do_rpt && cur_id == ID_W'(i) && !eq && cnt[i] != '1) begin
                cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    // Output packing
    always_comb begin
        ch_done      = '0;
        mismatch_cnt = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ch_done[i] = (ch_state[i] == CH_DONE);
            mismatch_cnt[i*CNT_W +: CNT_W] = cnt[i];
        end
        ch_match  = match_q;
        irq       = irq_q;
        irq_ch_id = irq_id_q;
    end

endmodule

// File: tb/tb_dwc_compare_scheduler.sv
// Directed table-driven bench for dwc_compare_scheduler (4 channels, 2-bit counters).
module tb_dwc_compare_scheduler;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 2;
    localparam int ID_W   = 2;

    logic                     clk;
    logic                     reset;
    logic [NUM_CH-1:0]        ch_valid_a;
    logic [NUM_CH-1:0]        ch_valid_b;
    logic [NUM_CH*DATA_W-1:0] ch_data_a;
    logic [NUM_CH*DATA_W-1:0] ch_data_b;
    logic [NUM_CH-1:0]        ch_ack;
    logic                     cnt_clr;
    logic [NUM_CH-1:0]        ch_done;
    logic [NUM_CH-1:0]        ch_match;
    logic                     irq;
    logic [ID_W-1:0]          irq_ch_id;
    logic [NUM_CH*CNT_W-1:0]  mismatch_cnt;

    dwc_compare_scheduler #(
        .NUM_CH(NUM_CH),
        .DATA_W(DATA_W),
        .CNT_W (CNT_W),
        .ID_W  (ID_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ch_valid_a  (ch_valid_a),
        .ch_valid_b  (ch_valid_b),
        .ch_data_a   (ch_data_a),
        .ch_data_b   (ch_data_b),
        .ch_ack      (ch_ack),
        .cnt_clr     (cnt_clr),
        .ch_done     (ch_done),
        .ch_match    (ch_match),
        .irq         (irq),
        .irq_ch_id   (irq_ch_id),
        .mismatch_cnt(mismatch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] va;
        logic [3:0] vb;
        logic [3:0] ack;
        logic       clr;
        logic [3:0] done;
        logic [3:0] match;
        logic       irq;
        logic [1:0] id;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [3:0] va, input logic [3:0] vb,
                       input logic [3:0] ack, input logic clr, input logic [3:0] done,
                       input logic [3:0] match, input logic irqv, input logic [1:0] id,
                       input logic [7:0] cnt);
        vec_t v;
        v.rst = rst; v.va = va; v.vb = vb; v.ack = ack; v.clr = clr;
        v.done = done; v.match = match; v.irq = irqv; v.id = id; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    initial begin
        int n;
        bit seen;

        //   rst va      vb      ack     clr done    match   irq id cnt
        // ch0 match, first completion visible after the third edge
        add(0, 4'b0001, 4'b0001, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 8'h00); // 0 grant
        add(0, 4'b0001, 4'b0001, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 8'h00); // 1 cmp
        add(0, 4'b0001, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0001, 1, 0, 8'h00); // 2 rpt
        add(0, 4'b0001, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0001, 0, 0, 8'h00); // 3 held
        add(0, 4'b0000, 4'b0000, 4'b0001, 0, 4'b0000, 4'b0000, 0, 0, 8'h00); // 4 release
        // ch2 mismatch x3, with ack held while valids remain high
        add(0, 4'b0100, 4'b0100, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 8'h00); // 5
        add(0, 4'b0100, 4'b0100, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 8'h00); // 6
        add(0, 4'b0100, 4'b0100, 4'b0000, 0, 4'b0100, 4'b0000, 1, 2, 8'h10); // 7
        add(0, 4'b0100, 4'b0100, 4'b0100, 0, 4'b0100, 4'b0000, 0, 2, 8'h10); // 8 ack, valids high
        add(0, 4'b0000, 4'b0100, 4'b0100, 0, 4'b0100, 4'b0000, 0, 2, 8'h10); // 9 one valid high
        add(0, 4'b0000, 4'b0000, 4'b0100, 0, 4'b0000, 4'b0000, 0, 2, 8'h10); // 10 release
        add(0, 4'b0100, 4'b0100, 4'b0000, 0, 4'b0000, 4'b0000, 0, 2, 8'h10); // 11
        add(0, 4'b0100, 4'b0100, 4'b0000, 0, 4'b0000, 4'b0000, 0, 2, 8'h10); // 12
        add(0, 4'b0100, 4'b0100, 4'b0000, 0, 4'b0100, 4'b0000, 1, 2, 8'h20); // 13
        add(0, 4'b0000, 4'b0000, 4'b0100, 0, 4'b0000, 4'b0000, 0, 2, 8'h20); // 14
        add(0, 4'b0100, 4'b0100, 4'b0000, 0, 4'b0000, 4'b0000, 0, 2, 8'h20); // 15
        add(0, 4'b0100, 4'b0100, 4'b0000, 0, 4'b0000, 4'b0000, 0, 2, 8'h20); // 16
        add(0, 4'b0100, 4'b0100, 4'b0000, 0, 4'b0100, 4'b0000, 1, 2, 8'h30); // 17
        add(0, 4'b0000, 4'b0000, 4'b0100, 0, 4'b0000, 4'b0000, 0, 2, 8'h30); // 18
        // saturation at 3, then clear coinciding with a mismatch report
        add(0, 4'b0100, 4'b0100, 4'b0000, 0, 4'b0000, 4'b0000, 0, 2, 8'h30); // 19
        add(0, 4'b0100, 4'b0100, 4'b0000, 0, 4'b0000, 4'b0000, 0, 2, 8'h30); // 20
        add(0, 4'b0100, 4'b0100, 4'b0000, 0, 4'b0100, 4'b0000, 1, 2, 8'h30); // 21 saturated
        add(0, 4'b0000, 4'b0000, 4'b0100, 0, 4'b0000, 4'b0000, 0, 2, 8'h30); // 22
        add(0, 4'b0100, 4'b0100, 4'b0000, 0, 4'b0000, 4'b0000, 0, 2, 8'h30); // 23
        add(0, 4'b0100, 4'b0100, 4'b0000, 0, 4'b0000, 4'b0000, 0, 2, 8'h30); // 24
        add(0, 4'b0100, 4'b0100, 4'b0000, 1, 4'b0100, 4'b0000, 1, 2, 8'h00); // 25 clr wins
        add(0, 4'b0000, 4'b0000, 4'b0100, 0, 4'b0000, 4'b0000, 0, 2, 8'h00); // 26
        // reset, then round-robin over all four channels
        add(1, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 8'h00); // 27
        add(0, 4'b1111, 4'b1111, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 8'h00); // 28 grant 0
        add(0, 4'b1111, 4'b1111, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 8'h00); // 29
        add(0, 4'b1111, 4'b1111, 4'b0000, 0, 4'b0001, 4'b0001, 1, 0, 8'h00); // 30
        add(0, 4'b1111, 4'b1111, 4'b0000, 0, 4'b0001, 4'b0001, 0, 0, 8'h00); // 31 grant 1
        add(0, 4'b1111, 4'b1111, 4'b0000, 0, 4'b0001, 4'b0001, 0, 0, 8'h00); // 32
        add(0, 4'b1111, 4'b1111, 4'b0000, 0, 4'b0011, 4'b0011, 1, 1, 8'h00); // 33
        add(0, 4'b1111, 4'b1111, 4'b0000, 0, 4'b0011, 4'b0011, 0, 1, 8'h00); // 34 grant 2
        add(0, 4'b1111, 4'b1111, 4'b0000, 0, 4'b0011, 4'b0011, 0, 1, 8'h00); // 35
        add(0, 4'b1111, 4'b1111, 4'b0000, 0, 4'b0111, 4'b0011, 1, 2, 8'h10); // 36
        add(0, 4'b1111, 4'b1111, 4'b0000, 0, 4'b0111, 4'b0011, 0, 2, 8'h10); // 37 grant 3
        add(0, 4'b1111, 4'b1111, 4'b0000, 0, 4'b0111, 4'b0011, 0, 2, 8'h10); // 38
        add(0, 4'b1111, 4'b1111, 4'b0000, 0, 4'b1111, 4'b0011, 1, 3, 8'h50); // 39 MSB-only diff
        add(0, 4'b1111, 4'b1111, 4'b0000, 0, 4'b1111, 4'b0011, 0, 3, 8'h50); // 40
        add(0, 4'b0000, 4'b0000, 4'b1111, 0, 4'b0000, 4'b0000, 0, 3, 8'h50); // 41 release all
        add(0, 4'b1010, 4'b1010, 4'b0000, 0, 4'b0000, 4'b0000, 0, 3, 8'h50); // 42 grant 1
        add(0, 4'b1010, 4'b1010, 4'b0000, 0, 4'b0000, 4'b0000, 0, 3, 8'h50); // 43
        add(0, 4'b1010, 4'b1010, 4'b0000, 0, 4'b0010, 4'b0010, 1, 1, 8'h50); // 44
        add(0, 4'b1010, 4'b1010, 4'b0000, 0, 4'b0010, 4'b0010, 0, 1, 8'h50); // 45 grant 3
        add(0, 4'b1010, 4'b1010, 4'b0000, 0, 4'b0010, 4'b0010, 0, 1, 8'h50); // 46
        add(0, 4'b1010, 4'b1010, 4'b0000, 0, 4'b1010, 4'b0010, 1, 3, 8'h90); // 47
        add(0, 4'b0000, 4'b0000, 4'b1111, 0, 4'b0000, 4'b0000, 0, 3, 8'h90); // 48
        // reset during ch3 compare, then ch3 regranted and completes
        add(0, 4'b1000, 4'b1000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 3, 8'h90); // 49 grant 3
        add(1, 4'b1000, 4'b1000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 8'h00); // 50 reset in CMP
        add(0, 4'b1000, 4'b1000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 8'h00); // 51 grant 3
        add(0, 4'b1000, 4'b1000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 8'h00); // 52
        add(0, 4'b1000, 4'b1000, 4'b0000, 0, 4'b1000, 4'b0000, 1, 3, 8'h40); // 53
        add(0, 4'b0000, 4'b0000, 4'b1000, 0, 4'b0000, 4'b0000, 0, 3, 8'h40); // 54
        add(0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 0, 3, 8'h00); // 55 clr alone

        // ch0 match, ch1 match, ch2 low bits differ, ch3 only MSB differs
        ch_data_a = {32'h8000_0000, 32'h0000_0001, 32'h1234_5678, 32'hDEAD_BEEF};
        ch_data_b = {32'h0000_0000, 32'h0000_0003, 32'h1234_5678, 32'hDEAD_BEEF};
        reset      = 1'b1;
        ch_valid_a = '0;
        ch_valid_b = '0;
        ch_ack     = '0;
        cnt_clr    = 1'b0;
        repeat (2) @(negedge clk);

        chk("reset_done",  -1, 32'(ch_done),      32'h0);
        chk("reset_match", -1, 32'(ch_match),     32'h0);
        chk("reset_irq",   -1, 32'(irq),          32'h0);
        chk("reset_id",    -1, 32'(irq_ch_id),    32'h0);
        chk("reset_cnt",   -1, 32'(mismatch_cnt), 32'h0);
        reset = 1'b0;

        for (int r = 0; r < tbl.size(); r++) begin
            reset      = tbl[r].rst;
            ch_valid_a = tbl[r].va;
            ch_valid_b = tbl[r].vb;
            ch_ack     = tbl[r].ack;
            cnt_clr    = tbl[r].clr;
            @(negedge clk);
            chk("done",  r, 32'(ch_done),      32'(tbl[r].done));
            chk("match", r, 32'(ch_match),     32'(tbl[r].match));
            chk("irq",   r, 32'(irq),          32'(tbl[r].irq));
            chk("id",    r, 32'(irq_ch_id),    32'(tbl[r].id));
            chk("cnt",   r, 32'(mismatch_cnt), 32'(tbl[r].cnt));
        end
        reset   = 1'b0;
        cnt_clr = 1'b0;

        // Data changed and valids dropped while BUSY: result reflects captured words
        ch_valid_a = 4'b0001;
        ch_valid_b = 4'b0001;
        @(negedge clk);
        ch_data_b[31:0] = 32'h0000_0000;
        ch_valid_a = '0;
        ch_valid_b = '0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 10) begin
            @(negedge clk);
            n++;
            seen = irq;
        end
        chk("late_irq_seen",  100, 32'(seen),        32'h1);
        chk("late_latency",   100, 32'(n),           32'h2);
        chk("late_match",     100, 32'(ch_match[0]), 32'h1);
        chk("late_id",        100, 32'(irq_ch_id),   32'h0);
        @(negedge clk);
        chk("irq_one_cycle",  101, 32'(irq),         32'h0);
        chk("held_done",      101, 32'(ch_done),     32'h1);
        ch_ack = 4'b0001;
        @(negedge clk);
        ch_ack = '0;
        chk("late_release",   102, 32'(ch_done),     32'h0);
        chk("late_cnt",       102, 32'(mismatch_cnt), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
